// File: rtl/ram_strb_pipe.sv
// Single-port scratch RAM with byte-strobe writes, a 1..4 stage read-return pipeline
// and a clear sequencer that zeroes one word per cycle after reset or a clr request.
module ram_strb_pipe #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 64,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH        = 128,
    parameter int RD_LATENCY   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cs,
    input  logic                    wr_enb,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [STROBE_WIDTH-1:0] strobe,
    input  logic                    clr,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    err
);

    localparam int OFF_W  = $clog2(STROBE_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state_q;
    logic [MEM_AW-1:0]       cnt_q;
    logic                    ready_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   pipe_q [RD_LATENCY];
    logic [RD_LATENCY-1:0]   vld_q;

    logic [IDX_W-1:0]        idx;
    logic [MEM_AW-1:0]       widx;
    logic                    oor;
    logic                    accept;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [DATA_WIDTH-1:0]   rd_word_d;
    logic                    unused_addr;

    assign idx         = addr[ADDR_WIDTH-1:OFF_W];
    assign widx        = idx[MEM_AW-1:0];
    assign oor         = int'(idx) >= DEPTH;
    assign accept      = (state_q == RUN) && cs && !clr;
    assign wr_acc      = accept && wr_enb;
    assign rd_acc      = accept && !wr_enb;
    assign rd_word_d   = oor ? '0 : mem[widx];
    assign unused_addr = ^addr;

    // Clear sequencer: INIT walks every word once, clr in RUN restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && oor;
            case (state_q)
                INIT: begin
                    if (cnt_q == MEM_AW'(DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + MEM_AW'(1);
                    end
                end
                RUN: begin
                    if (clr) begin
                        state_q <= INIT;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Storage array: no reset, contents are defined by the clear sequencer.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc && !oor) begin
            for (int i = 0; i < STROBE_WIDTH; i++) begin
                if (strobe[i]) begin
                    mem[widx][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Read return: each data stage loads only behind a valid, so the last one holds between returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                pipe_q[0] <= rd_word_d;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end
    end

    assign ready    = ready_q;
    assign err      = err_q;
    assign rd_valid = vld_q[RD_LATENCY-1];
    assign data_out = pipe_q[RD_LATENCY-1];

endmodule

// File: tb/tb_ram_strb_pipe.sv
// Bench for ram_strb_pipe: three configurations share one stimulus stream and are
// compared every cycle against a per-configuration behavioural model.
module tb_ram_strb_pipe;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        wr_enb = 1'b0;
    logic        clr = 1'b0;
    logic [9:0]  addr = '0;
    logic [63:0] data_in = '0;
    logic [7:0]  strobe = '0;

    logic        rdy  [ND];
    logic        vld  [ND];
    logic        er   [ND];
    logic [63:0] dout [ND];

    ram_strb_pipe #(.DEPTH(128), .RD_LATENCY(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_enb(wr_enb), .addr(addr),
        .data_in(data_in), .strobe(strobe), .clr(clr),
        .ready(rdy[0]), .data_out(dout[0]), .rd_valid(vld[0]), .err(er[0]));

    ram_strb_pipe #(.DEPTH(64), .RD_LATENCY(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_enb(wr_enb), .addr(addr),
        .data_in(data_in), .strobe(strobe), .clr(clr),
        .ready(rdy[1]), .data_out(dout[1]), .rd_valid(vld[1]), .err(er[1]));

    ram_strb_pipe #(.DEPTH(128), .RD_LATENCY(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_enb(wr_enb), .addr(addr),
        .data_in(data_in), .strobe(strobe), .clr(clr),
        .ready(rdy[2]), .data_out(dout[2]), .rd_valid(vld[2]), .err(er[2]));

    always #5 clk = ~clk;

    // Reference state: word contents, remaining clear cycles, and a time-indexed return schedule.
    logic [63:0] mm [ND][128];
    int          init_left [ND];
    logic        exp_err [ND];
    logic [63:0] exp_do [ND];
    logic        sv [ND][8];
    logic [63:0] sd [ND][8];
    int          edge_n = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int dep_of(input int d);
        return (d == 1) ? 64 : 128;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            init_left[d] = dep_of(d);
            exp_err[d]   = 1'b0;
            exp_do[d]    = '0;
            for (int s = 0; s < 8; s++) begin
                sv[d][s] = 1'b0;
                sd[d][s] = '0;
            end
            for (int w = 0; w < 128; w++) mm[d][w] = '0;
        end
    endtask

    task automatic model_edge();
        int idx;
        bit oor;
        edge_n++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < ND; d++) begin
            exp_err[d] = 1'b0;
            if (init_left[d] > 0) begin
                init_left[d]--;
            end else if (clr) begin
                init_left[d] = dep_of(d);
                for (int w = 0; w < 128; w++) mm[d][w] = '0;
            end else if (cs) begin
                idx = int'(addr >> 3);
                oor = idx >= dep_of(d);
                exp_err[d] = oor;
                if (wr_enb) begin
                    if (!oor)
                        for (int b = 0; b < 8; b++)
                            if (strobe[b]) mm[d][idx][8*b +: 8] = data_in[8*b +: 8];
                end else begin
                    sv[d][(edge_n + lat_of(d) - 1) % 8] = 1'b1;
                    sd[d][(edge_n + lat_of(d) - 1) % 8] = oor ? 64'd0 : mm[d][idx];
                end
            end
        end
    endtask

    task automatic check_outs(input string ph);
        logic exp_v;
        int   s;
        s = edge_n % 8;
        for (int d = 0; d < ND; d++) begin
            exp_v = sv[d][s];
            if (exp_v) exp_do[d] = sd[d][s];
            sv[d][s] = 1'b0;
            chk($sformatf("%s.ready%0d", ph, d), 64'(rdy[d]), 64'(init_left[d] == 0));
            chk($sformatf("%s.rd_valid%0d", ph, d), 64'(vld[d]), 64'(exp_v));
            chk($sformatf("%s.data_out%0d", ph, d), dout[d], exp_do[d]);
            chk($sformatf("%s.err%0d", ph, d), 64'(er[d]), 64'(exp_err[d]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outs("cyc");
    endtask

    task automatic drive(input logic c, input logic w, input logic [9:0] a,
                         input logic [63:0] dat, input logic [7:0] st, input logic cl);
        cs = c; wr_enb = w; addr = a; data_in = dat; strobe = st; clr = cl;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [9:0] a, input logic [63:0] dat, input logic [7:0] st);
        drive(1'b1, 1'b1, a, dat, st, 1'b0);
    endtask

    task automatic rd(input logic [9:0] a);
        drive(1'b1, 1'b0, a, '0, 8'hA5, 1'b0);
    endtask

    task automatic reset_pulse(input string ph);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs(ph);
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] rdat;
        model_reset();
        #3;
        check_outs("por");
        idle(2);
        rst_n = 1'b1;
        idle(130);

        rd(10'd0); rd(10'd616); rd(10'd1016);
        idle(5);

        wr(10'd78, 64'h78ac_d090_5678_9012, 8'hFF);
        rd(10'd78);
        idle(1);
        chk("vec_full_write", dout[0], 64'h78ac_d090_5678_9012);
        idle(4);

        wr(10'd143, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        rd(10'd143);
        idle(1);
        chk("vec_low_lanes", dout[0], 64'h0000_0000_FFFF_FFFF);
        idle(4);

        wr(10'd600, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        chk("oor_wr_err", 64'(er[1]), 64'd1);
        rd(10'd600);
        chk("oor_rd_err", 64'(er[1]), 64'd1);
        rd(10'd88);
        idle(5);
        wr(10'd160, 64'h1111_2222_3333_4444, 8'h00);
        rd(10'd160);
        idle(5);

        for (int i = 0; i < 4; i++) wr(10'(8 * (20 + i)), {$urandom, $urandom}, 8'hFF);
        for (int i = 0; i < 4; i++) rd(10'(8 * (20 + i)));
        idle(5);
        wr(10'd240, 64'hCAFE_F00D_5555_AAAA, 8'h3C);
        rd(10'd240);
        idle(5);

        wr(10'd40, 64'h0505_0505_0505_0505, 8'hFF);
        rd(10'd40);
        drive(1'b1, 1'b0, 10'd40, '0, '0, 1'b1);
        idle(130);
        rd(10'd40);
        idle(5);

        for (int i = 0; i < 700; i++) begin
            rdat = {$urandom, $urandom};
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 255)) : 10'($urandom_range(0, 1023)),
                  rdat, 8'($urandom), $urandom_range(0, 149) == 0);
        end
        idle(130);

        wr(10'd8, 64'h0123_4567_89AB_CDEF, 8'hFF);
        rd(10'd8);
        rd(10'd16);
        reset_pulse("rst_mid");
        idle(130);
        rd(10'd8);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
